// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-writer counters between ID issue and WB.
// Stalls ID on a RAW hazard against an in-flight writer, or when the destination
// counter is saturated. Optional macro SCOREBOARD_WB_BYPASS_EN lets a source whose
// only pending writer is retiring this cycle issue, relying on WB-to-ID forwarding.

// One pending-writer counter; inc and dec in the same cycle cancel.
module reg_cnt_slot #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);
  // clear on flush, otherwise net +1/-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (inc && !dec) cnt <= cnt + CNT_W'(1);
    else if (dec && !inc) cnt <= cnt - CNT_W'(1);
  end
endmodule

module reg_scoreboard #(
  parameter int REG_ID_W = 5,
  parameter int NUM_REGS = 2**REG_ID_W,
  parameter int CNT_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [REG_ID_W-1:0]       issue_rs1,
  input  logic [REG_ID_W-1:0]       issue_rs2,
  input  logic                      issue_rs1_used,
  input  logic                      issue_rs2_used,
  input  logic [REG_ID_W-1:0]       issue_rd,
  input  logic                      issue_wen,
  input  logic                      wb_valid,
  input  logic [REG_ID_W-1:0]       wb_rd,
  input  logic                      flush,
  output logic [NUM_REGS-1:0]       busy_vec,
  output logic [REG_ID_W+CNT_W-1:0] outstanding,
  output logic                      err_underflow
);
  localparam int OUT_W = REG_ID_W + CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
  logic bypass_rs1, bypass_rs2;
  logic hazard_rs1, hazard_rs2, sat;
  logic issue_wr, wb_try, wb_ret;

  assign cnt_rs1 = cnt[issue_rs1];
  assign cnt_rs2 = cnt[issue_rs2];
  assign cnt_rd  = cnt[issue_rd];
  assign cnt_wb  = cnt[wb_rd];

`ifdef SCOREBOARD_WB_BYPASS_EN
  // last pending writer retires now: WB forwarding covers the read
  assign bypass_rs1 = wb_valid && (wb_rd == issue_rs1) && (cnt_rs1 == CNT_W'(1));
  assign bypass_rs2 = wb_valid && (wb_rd == issue_rs2) && (cnt_rs2 == CNT_W'(1));
`else
  assign bypass_rs1 = 1'b0;
  assign bypass_rs2 = 1'b0;
`endif

  assign hazard_rs1 = issue_rs1_used && (issue_rs1 != '0) && (cnt_rs1 != '0) && !bypass_rs1;
  assign hazard_rs2 = issue_rs2_used && (issue_rs2 != '0) && (cnt_rs2 != '0) && !bypass_rs2;
  assign sat        = issue_wen && (issue_rd != '0) && (cnt_rd == CNT_MAX);
  assign issue_ready = !(hazard_rs1 || hazard_rs2 || sat || flush);

  // ready already excludes flush, so a fire never coincides with a flush
  assign issue_wr = issue_valid && issue_ready && issue_wen && (issue_rd != '0);
  assign wb_try   = wb_valid && (wb_rd != '0) && !flush;
  assign wb_ret   = wb_try && (cnt_wb != '0);

  // one counter per register; slot 0 never sees inc/dec and stays at zero
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
    logic inc, dec;
    assign inc = issue_wr && (issue_rd == REG_ID_W'(i));
    assign dec = wb_ret   && (wb_rd    == REG_ID_W'(i));
    reg_cnt_slot #(.CNT_W(CNT_W)) u_slot (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (flush),
      .inc  (inc),
      .dec  (dec),
      .cnt  (cnt[i])
    );
  end

  // busy bits are a pure view of the counter state
  always_comb begin
    busy_vec = '0;
    for (int i = 1; i < NUM_REGS; i++) busy_vec[i] = (cnt[i] != '0);
  end

  // running sum of all counters, tracked by the same inc/dec events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   outstanding <= '0;
    else if (flush)               outstanding <= '0;
    else if (issue_wr && !wb_ret) outstanding <= outstanding + OUT_W'(1);
    else if (wb_ret && !issue_wr) outstanding <= outstanding - OUT_W'(1);
  end

  // sticky underflow flag; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         err_underflow <= 1'b0;
    else if (wb_try && cnt_wb == '0)    err_underflow <= 1'b1;
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: a reference model pushes expected state to a
// queue when each step is driven; the entry is popped and compared after the edge.
module tb_reg_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd, wb_rd;
  logic        issue_rs1_used, issue_rs2_used, issue_wen, wb_valid, flush;
  logic [31:0] busy_vec;
  logic [6:0]  outstanding;
  logic        err_underflow;

  reg_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_wen(issue_wen),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .busy_vec(busy_vec), .outstanding(outstanding), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] busy;
    logic [6:0]  outs;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // reference state
  int unsigned mc[32];
  int unsigned mo;
  bit          merr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    bit h1, h2, s;
    h1 = issue_rs1_used && issue_rs1 != 0 && mc[issue_rs1] != 0 &&
         !(BYPASS && mc[issue_rs1] == 1 && wb_valid && wb_rd == issue_rs1);
    h2 = issue_rs2_used && issue_rs2 != 0 && mc[issue_rs2] != 0 &&
         !(BYPASS && mc[issue_rs2] == 1 && wb_valid && wb_rd == issue_rs2);
    s  = issue_wen && issue_rd != 0 && mc[issue_rd] == 3;
    return !(h1 || h2 || s || flush);
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    for (int i = 1; i < 32; i++) b[i] = (mc[i] != 0);
    return b;
  endfunction

  task automatic drive(input logic iv, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                       input logic wen, input logic wv, input logic [4:0] wrd,
                       input logic fl);
    issue_valid = iv; issue_rs1 = r1; issue_rs1_used = u1;
    issue_rs2 = r2; issue_rs2_used = u2; issue_rd = rd; issue_wen = wen;
    wb_valid = wv; wb_rd = wrd; flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // drive, check ready against the model, push expected state, clock, pop and compare
  task automatic step(input string tag, input logic iv, input logic [4:0] r1,
                      input logic u1, input logic [4:0] r2, input logic u2,
                      input logic [4:0] rd, input logic wen, input logic wv,
                      input logic [4:0] wrd, input logic fl);
    bit rdy;
    exp_t e, got;
    drive(iv, r1, u1, r2, u2, rd, wen, wv, wrd, fl);
    #1;
    rdy = m_ready();
    chk({tag, ".ready"}, 64'(issue_ready), 64'(rdy));
    if (fl) begin
      for (int i = 0; i < 32; i++) mc[i] = 0;
      mo = 0;
    end else begin
      if (wv && wrd != 0) begin
        if (mc[wrd] == 0) merr = 1;
        else begin mc[wrd]--; mo--; end
      end
      if (iv && rdy && wen && rd != 0) begin mc[rd]++; mo++; end
    end
    e.tag = tag; e.busy = m_busy(); e.outs = 7'(mo); e.err = merr;
    exp_q.push_back(e);
    @(posedge clk); #1;
    got = exp_q.pop_front();
    chk({got.tag, ".busy"}, 64'(busy_vec), 64'(got.busy));
    chk({got.tag, ".outs"}, 64'(outstanding), 64'(got.outs));
    chk({got.tag, ".err"},  64'(err_underflow), 64'(got.err));
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mc[i] = 0;
    mo = 0; merr = 0;
    rst_n = 1'b0;
    idle();
    #2;
    chk("rst.busy", 64'(busy_vec), 64'h0);
    chk("rst.outs", 64'(outstanding), 64'h0);
    chk("rst.err",  64'(err_underflow), 64'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // rd=5 becomes busy, blocks a reader of r5, clears after WB
    step("iss5", 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    chk("iss5.bit", 64'(busy_vec[5]), 64'h1);
    chk("iss5.out", 64'(outstanding), 64'h1);
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("raw5.stall", 64'(issue_ready), 64'h0);
    step("wb5", 0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("raw5.free", 64'(issue_ready), 64'h1);
    chk("wb5.bit", 64'(busy_vec[5]), 64'h0);
    idle();

    // saturate r3 then release one slot
    for (int k = 0; k < 3; k++) step("iss3", 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    chk("sat3.out", 64'(outstanding), 64'h3);
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); #1;
    chk("sat3.stall", 64'(issue_ready), 64'h0);
    step("sat3.try", 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    step("wb3", 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); #1;
    chk("sat3.free", 64'(issue_ready), 64'h1);
    idle();

    // same-cycle issue/retire on one register, then on different registers
    step("iss7", 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    step("iss7wb7", 1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
    chk("iss7wb7.out", 64'(outstanding), 64'h3);
    chk("iss7wb7.bit", 64'(busy_vec[7]), 64'h1);
    step("iss8wb7", 1, 0, 0, 0, 0, 8, 1, 1, 7, 0);
    chk("iss8wb7.b8", 64'(busy_vec[8]), 64'h1);
    chk("iss8wb7.b7", 64'(busy_vec[7]), 64'h0);

    // register 0 is never tracked; underflow is sticky across flush
    step("r0", 1, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    chk("r0.bit", 64'(busy_vec[0]), 64'h0);
    step("wb9under", 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    chk("under.err", 64'(err_underflow), 64'h1);

    // flush wins over a concurrent issue and retire
    step("iss4a", 1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    step("iss4b", 1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    step("iss6",  1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 4, 1, 1, 6, 1); #1;
    chk("flush.ready", 64'(issue_ready), 64'h0);
    step("flush", 1, 0, 0, 0, 0, 4, 1, 1, 6, 1);
    chk("flush.busy", 64'(busy_vec), 64'h0);
    chk("flush.out", 64'(outstanding), 64'h0);
    chk("flush.err", 64'(err_underflow), 64'h1);

    // retiring writer of a source in the issue cycle
    step("iss10", 1, 0, 0, 0, 0, 10, 1, 0, 0, 0);
    drive(1, 0, 0, 10, 1, 0, 0, 1, 10, 0); #1;
    chk("byp10.ready", 64'(issue_ready), 64'(BYPASS));
    step("byp10", 1, 0, 0, 10, 1, 0, 0, 1, 10, 0);
    drive(1, 0, 0, 10, 1, 0, 0, 0, 0, 0); #1;
    chk("byp10.next", 64'(issue_ready), 64'h1);
    idle();

    // asynchronous reset in the middle of a cycle
    step("pre1", 1, 0, 0, 0, 0, 11, 1, 0, 0, 0);
    step("pre2", 1, 0, 0, 0, 0, 12, 1, 0, 0, 0);
    step("pre3", 1, 0, 0, 0, 0, 13, 1, 0, 0, 0);
    step("pre4", 1, 0, 0, 0, 0, 13, 1, 0, 0, 0);
    chk("pre.out", 64'(outstanding), 64'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy", 64'(busy_vec), 64'h0);
    chk("arst.out",  64'(outstanding), 64'h0);
    chk("arst.err",  64'(err_underflow), 64'h0);
    for (int i = 0; i < 32; i++) mc[i] = 0;
    mo = 0; merr = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    step("post", 1, 0, 0, 0, 0, 14, 1, 0, 0, 0);
    chk("q.empty", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
